// File: rtl/fifo_sync_flex_pkg.sv
// rtl/fifo_sync_flex_pkg.sv - read modes, flag bundle and helpers shared by fifo_sync_flex
package fifo_sync_flex_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  // Flag state of an empty FIFO: every legal AE_LEVEL covers count 0, no legal AF_LEVEL does
  localparam fifo_flags_t FIFO_FLAGS_RESET = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// rtl/fifo_ram_sdp.sv - simple dual-port RAM, one write port, one registered read port
module fifo_ram_sdp #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-address write returns the old word, and clr keeps X off the output
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_flex.sv
// rtl/fifo_sync_flex.sv - single-clock FIFO with count, thresholds, flush and show-ahead mode
module fifo_sync_flex
  import fifo_sync_flex_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_clr,
  input  logic              fifo_wr_en,
  input  logic [WIDTH-1:0]  fifo_wr_data,
  input  logic              fifo_rd_en,
  output logic [WIDTH-1:0]  fifo_rd_data,
  output logic              fifo_rd_valid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_afull,
  output logic              fifo_aempty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_ovf,
  output logic              fifo_udf
);

  localparam bit             IS_FWFT = (FWFT == FIFO_MODE_FWFT);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("fifo_sync_flex: DEPTH must be a power of 2 and at least 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_level
    $error("fifo_sync_flex: AF_LEVEL or AE_LEVEL out of range");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("fifo_sync_flex: FWFT must be 0 or 1");
  end

  logic [ADDR_W:0] wr_ptr, rd_ptr, count_q, count_nxt, ram_words;
  logic            clr_all, wr_acc, rd_acc, ram_rd, rd_valid_q, rd_valid_nxt;
  logic            ovf_q, udf_q;
  fifo_flags_t     flags_q, flags_nxt;

  assign clr_all = rst | fifo_clr;
  // Words in the RAM that have not yet been moved to the output register
  assign ram_words = wr_ptr - rd_ptr;

  // Acceptance, RAM fetch and next count/flags; flags derive from the next count so they
  // register in step with fifo_count
  always_comb begin
    rd_acc = fifo_rd_en & ~flags_q.empty;
    wr_acc = fifo_wr_en & (~flags_q.full | rd_acc);
    if (IS_FWFT) begin
      // Refill the show-ahead register whenever it is free or being popped
      ram_rd       = (~rd_valid_q | rd_acc) & (ram_words != '0);
      rd_valid_nxt = ram_rd | (rd_valid_q & ~rd_acc);
    end else begin
      ram_rd       = rd_acc;
      rd_valid_nxt = rd_acc;
    end
    count_nxt = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count_q - 1'b1;
    end
    flags_nxt.full   = (count_nxt == DEPTH_C);
    flags_nxt.afull  = (count_nxt >= AF_C);
    flags_nxt.aempty = (count_nxt <= AE_C);
    flags_nxt.empty  = IS_FWFT ? ~rd_valid_nxt : (count_nxt == '0);
  end

  // Pointers, count, flags and error pulses; reset beats flush, both abort the current access
  always_ff @(posedge clk) begin
    if (clr_all) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      flags_q    <= FIFO_FLAGS_RESET;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q    <= count_nxt;
      rd_valid_q <= rd_valid_nxt;
      flags_q    <= flags_nxt;
      ovf_q      <= fifo_wr_en & ~wr_acc;
      udf_q      <= fifo_rd_en & ~rd_acc;
    end
  end

  fifo_ram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .clr  (clr_all),
    .we   (wr_acc & ~clr_all),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(fifo_wr_data),
    .re   (ram_rd & ~clr_all),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(fifo_rd_data)
  );

  assign fifo_rd_valid = rd_valid_q;
  assign fifo_full     = flags_q.full;
  assign fifo_empty    = flags_q.empty;
  assign fifo_afull    = flags_q.afull;
  assign fifo_aempty   = flags_q.aempty;
  assign fifo_count    = count_q;
  assign fifo_ovf      = ovf_q;
  assign fifo_udf      = udf_q;

endmodule

// File: tb/tb_fifo_sync_flex.sv
// tb/tb_fifo_sync_flex.sv - self-checking bench for fifo_sync_flex in standard and show-ahead modes
module tb_fifo_sync_flex;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] wd = 8'h00;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_flex #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .fifo_clr(clr), .fifo_wr_en(wr), .fifo_wr_data(wd), .fifo_rd_en(rd),
    .fifo_rd_data(s_rd_data), .fifo_rd_valid(s_rd_valid), .fifo_full(s_full),
    .fifo_empty(s_empty), .fifo_afull(s_afull), .fifo_aempty(s_aempty),
    .fifo_count(s_count), .fifo_ovf(s_ovf), .fifo_udf(s_udf)
  );

  fifo_sync_flex #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .fifo_clr(clr), .fifo_wr_en(wr), .fifo_wr_data(wd), .fifo_rd_en(rd),
    .fifo_rd_data(f_rd_data), .fifo_rd_valid(f_rd_valid), .fifo_full(f_full),
    .fifo_empty(f_empty), .fifo_afull(f_afull), .fifo_aempty(f_aempty),
    .fifo_count(f_count), .fifo_ovf(f_ovf), .fifo_udf(f_udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference models: a queue of every stored word plus the visible read port
  logic [7:0] sq[$];
  logic [7:0] fq[$];
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0, s_ovf_m = 1'b0, s_udf_m = 1'b0;
  logic       f_sv = 1'b0, f_ovf_m = 1'b0, f_udf_m = 1'b0;

  always @(posedge clk) begin
    logic ok_r, ok_w;
    logic [7:0] junk;
    if (rst || clr) begin
      sq.delete();
      s_valid = 1'b0; s_data = 8'h00; s_ovf_m = 1'b0; s_udf_m = 1'b0;
      fq.delete();
      f_sv = 1'b0; f_ovf_m = 1'b0; f_udf_m = 1'b0;
    end else begin
      ok_r = rd && (sq.size() > 0);
      ok_w = wr && (sq.size() < 16 || ok_r);
      s_ovf_m = wr && !ok_w;
      s_udf_m = rd && !ok_r;
      s_valid = ok_r;
      if (ok_r) s_data = sq.pop_front();
      if (ok_w) sq.push_back(wd);

      ok_r = rd && f_sv;
      ok_w = wr && (fq.size() < 16 || ok_r);
      f_ovf_m = wr && !ok_w;
      f_udf_m = rd && !ok_r;
      if (ok_r) junk = fq.pop_front();
      // A word already stored before this edge becomes the visible head after it
      f_sv = (fq.size() > 0);
      if (ok_w) fq.push_back(wd);
    end
  end

  always @(negedge clk) begin
    chk("s_count", 32'(s_count), 32'(sq.size()));
    chk("s_full", 32'(s_full), 32'(sq.size() == 16));
    chk("s_afull", 32'(s_afull), 32'(sq.size() >= 14));
    chk("s_aempty", 32'(s_aempty), 32'(sq.size() <= 2));
    chk("s_empty", 32'(s_empty), 32'(sq.size() == 0));
    chk("s_ovf", 32'(s_ovf), 32'(s_ovf_m));
    chk("s_udf", 32'(s_udf), 32'(s_udf_m));
    chk("s_rd_valid", 32'(s_rd_valid), 32'(s_valid));
    chk("s_rd_data", 32'(s_rd_data), 32'(s_data));
    chk("f_count", 32'(f_count), 32'(fq.size()));
    chk("f_full", 32'(f_full), 32'(fq.size() == 16));
    chk("f_afull", 32'(f_afull), 32'(fq.size() >= 14));
    chk("f_aempty", 32'(f_aempty), 32'(fq.size() <= 2));
    chk("f_empty", 32'(f_empty), 32'(!f_sv));
    chk("f_ovf", 32'(f_ovf), 32'(f_ovf_m));
    chk("f_udf", 32'(f_udf), 32'(f_udf_m));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(f_sv));
    if (f_sv) chk("f_rd_data", 32'(f_rd_data), 32'(fq[0]));
    else chk("f_data_known", 32'($isunknown(f_rd_data)), 32'(0));
  end

  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    wr = w; rd = r; wd = d; clr = c;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("lit_reset_count", 32'(s_count), 32'd0);
    chk("lit_reset_empty", 32'(s_empty), 32'd1);
    chk("lit_reset_aempty", 32'(f_aempty), 32'd1);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      chk("lit_afull_level", 32'(s_afull), 32'(i >= 13));
    end
    chk("lit_full", 32'(s_full), 32'd1);
    cyc(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("lit_ovf", 32'(s_ovf), 32'd1);
    chk("lit_ovf_count", 32'(s_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("lit_drain_data", 32'(s_rd_data), 32'(i));
    end
    chk("lit_drained_empty", 32'(s_empty), 32'd1);

    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("lit_udf", 32'(s_udf), 32'd1);
    cyc(1'b1, 1'b1, 8'h33, 1'b0);
    chk("lit_wr_rd_empty_count", 32'(s_count), 32'd1);
    chk("lit_wr_rd_empty_udf", 32'(s_udf), 32'd1);
    repeat (3) cyc(1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h80 + k), 1'b0);
      chk("lit_full_wr_rd_ovf", 32'(s_ovf), 32'd0);
      chk("lit_full_wr_rd_count", 32'(s_count), 32'd16);
      chk("lit_full_wr_rd_data", 32'(s_rd_data), 32'(8'h40 + k));
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("lit_order_after_full", 32'(s_rd_data), (i < 12) ? 32'(8'h44 + i) : 32'(8'h80 + i - 12));
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);

    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("lit_fwft_lat1_valid", 32'(f_rd_valid), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("lit_fwft_lat2_valid", 32'(f_rd_valid), 32'd1);
    chk("lit_fwft_lat2_data", 32'(f_rd_data), 32'hA5);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
      if (i >= 1) begin
        chk("lit_stream_valid", 32'(f_rd_valid), 32'd1);
        chk("lit_stream_data", 32'(f_rd_data), 32'(8'hC0 + i - 1));
      end
    end
    repeat (4) cyc(1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    chk("lit_count9", 32'(s_count), 32'd9);
    cyc(1'b1, 1'b0, 8'hDD, 1'b1);
    chk("lit_clr_count", 32'(s_count), 32'd0);
    chk("lit_clr_empty", 32'(s_empty), 32'd1);
    chk("lit_clr_fcount", 32'(f_count), 32'd0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("lit_clr_discard_udf", 32'(s_udf), 32'd1);
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("lit_rst_prefetch_valid", 32'(f_rd_valid), 32'd0);
    chk("lit_rst_prefetch_count", 32'(f_count), 32'd0);

    for (int i = 0; i < 100; i++) begin
      if (i < 50) cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'b0);
      else cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'b0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
